// File: rtl/interconnect_arb_pkg.sv
// interconnect_arb_pkg: shared constants and FSM state type for the interconnect arbiter.
package interconnect_arb_pkg;
   localparam int FUNC_W         = 2;
   localparam int NUM_REQ        = 2;
   localparam int DATA_W_DEFAULT = 8;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant; the pointer resets so requester 0 wins the first tie.
module rr_arbiter_2
   import interconnect_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant
);
   logic last_q, last_d;
   always_comb begin
      grant  = (valid == 2'b11) ? (last_q ? 2'b01 : 2'b10) : valid;
      last_d = (advance && |grant) ? grant[1] : last_q;
   end
   always_ff @(posedge clk) begin
      last_q <= rst ? 1'b1 : last_d;
   end
endmodule

// File: rtl/interconnect_arbiter.sv
// interconnect_arbiter: two-requester round-robin front end for a shared single-issue datapath.
// Per-requester saturating grant counters exist only when INTERCONNECT_ARB_STATS_EN is defined.
module interconnect_arbiter
   import interconnect_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_src,
   input  logic [NUM_REQ*FUNC_W-1:0] req_func,
   input  logic [NUM_REQ*DATA_W-1:0] req_in,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic [DATA_W-1:0]         dp_inbus,
   output logic [DATA_W-1:0]         dp_aside,
   output logic [DATA_W-1:0]         dp_bside,
   output logic                      dp_select_source,
   output logic [FUNC_W-1:0]         dp_function,
   input  logic [DATA_W-1:0]         dp_outbus,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [15:0]               grant_cnt
);
   state_e               state_q, state_d;
   logic [DATA_W-1:0]    in_q, in_d, a_q, a_d, b_q, b_d, rdata_q, rdata_d;
   logic [FUNC_W-1:0]    func_q, func_d;
   logic                 src_q, src_d, gnt_q, gnt_d, rid_q, rid_d, issue, gid;
   logic [NUM_REQ-1:0]   grant;

   rr_arbiter_2 u_rr (
      .clk     (clk),
      .rst     (rst),
      .valid   (req_valid),
      .advance (issue),
      .grant   (grant)
   );

   always_comb begin
      issue     = !rst && state_q == IDLE && |req_valid;
      gid       = grant[1];
      req_ready = issue ? grant : '0;
      state_d   = issue ? EXEC : (state_q == EXEC) ? RESP : (state_q == RESP && rsp_ready) ? IDLE : state_q;
      in_d      = issue ? (gid ? req_in[2*DATA_W-1:DATA_W] : req_in[DATA_W-1:0]) : in_q;
      a_d       = issue ? (gid ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0]) : a_q;
      b_d       = issue ? (gid ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0]) : b_q;
      src_d     = issue ? req_src[gid] : src_q;
      func_d    = issue ? (gid ? req_func[2*FUNC_W-1:FUNC_W] : req_func[FUNC_W-1:0]) : func_q;
      gnt_d     = issue ? gid : gnt_q;
      rdata_d   = (state_q == EXEC) ? dp_outbus : rdata_q;
      rid_d     = (state_q == EXEC) ? gnt_q : rid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         in_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         src_q   <= 1'b0;
         func_q  <= '0;
         gnt_q   <= 1'b0;
         rdata_q <= '0;
         rid_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         in_q    <= in_d;
         a_q     <= a_d;
         b_q     <= b_d;
         src_q   <= src_d;
         func_q  <= func_d;
         gnt_q   <= gnt_d;
         rdata_q <= rdata_d;
         rid_q   <= rid_d;
      end
   end

   assign dp_inbus         = in_q;
   assign dp_aside         = a_q;
   assign dp_bside         = b_q;
   assign dp_select_source = src_q;
   assign dp_function      = func_q;
   assign rsp_valid        = state_q == RESP;
   assign rsp_id           = rid_q;
   assign rsp_data         = rdata_q;

`ifdef INTERCONNECT_ARB_STATS_EN
   // Byte lane {gid,3'b000} holds the granted requester's count.
   logic [15:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = cnt_q;
      if (issue && cnt_q[{gid, 3'b000} +: 8] != 8'hff)
         cnt_d[{gid, 3'b000} +: 8] = cnt_q[{gid, 3'b000} +: 8] + 8'd1;
   end
   always_ff @(posedge clk) begin
      cnt_q <= rst ? '0 : cnt_d;
   end
   assign grant_cnt = cnt_q;
`else
   assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_interconnect_arbiter.sv
// tb_interconnect_arbiter: scoreboard bench with a cycle model of grant order, latency and hold behaviour.
module tb_interconnect_arbiter;
   localparam int DW = 8;

   logic          clk = 1'b0, rst = 1'b1;
   logic [1:0]    req_valid = '0, req_src = '0, req_ready;
   logic [3:0]    req_func = '0;
   logic [2*DW-1:0] req_in = '0, req_a = '0, req_b = '0;
   logic [DW-1:0] dp_inbus, dp_aside, dp_bside, dp_outbus, rsp_data;
   logic          dp_select_source, rsp_valid, rsp_id;
   logic          rsp_ready = 1'b1;
   logic [1:0]    dp_function;
   logic [15:0]   grant_cnt;

   int n_tests = 0, n_fail = 0;
   bit mon_en = 1'b0;

   typedef struct packed {logic id; logic [DW-1:0] data;} rsp_t;
   rsp_t sb[$];

   int            m_st = 0;
   logic          m_last = 1'b1, g;
   logic [DW-1:0] m_in = '0, m_a = '0, m_b = '0;
   logic          m_src = 1'b0;
   logic [1:0]    m_func = '0, exp_rdy;
   rsp_t          m_rsp = '0;
   int            m_cnt[2] = '{0, 0};
   logic [15:0]   exp_cnt;

   assign dp_outbus = dp_aside ^ dp_bside;

   interconnect_arbiter #(.DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src), .req_func(req_func),
      .req_in(req_in), .req_a(req_a), .req_b(req_b),
      .dp_inbus(dp_inbus), .dp_aside(dp_aside), .dp_bside(dp_bside),
      .dp_select_source(dp_select_source), .dp_function(dp_function), .dp_outbus(dp_outbus),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .grant_cnt(grant_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model of the current cycle: compare all outputs, then advance as the next clock edge would.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_rdy = (!rst && m_st == 0) ? ((req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid) : 2'b00;
`ifdef INTERCONNECT_ARB_STATS_EN
         exp_cnt = {8'(m_cnt[1]), 8'(m_cnt[0])};
`else
         exp_cnt = 16'd0;
`endif
         check("req_ready", req_ready, exp_rdy);
         check("rsp_valid", rsp_valid, m_st == 2);
         check("rsp_id", rsp_id, m_rsp.id);
         check("rsp_data", rsp_data, m_rsp.data);
         check("dp_inbus", dp_inbus, m_in);
         check("dp_aside", dp_aside, m_a);
         check("dp_bside", dp_bside, m_b);
         check("dp_src", dp_select_source, m_src);
         check("dp_func", dp_function, m_func);
         check("grant_cnt", grant_cnt, exp_cnt);
         if (rst) begin
            m_st = 0; m_last = 1'b1; m_in = '0; m_a = '0; m_b = '0; m_src = 1'b0; m_func = '0;
            m_rsp = '0; m_cnt = '{0, 0};
            sb.delete();
         end else if (m_st == 0 && exp_rdy != 2'b00) begin
            g      = exp_rdy[1];
            m_last = g;
            m_in   = g ? req_in[15:8] : req_in[7:0];
            m_a    = g ? req_a[15:8] : req_a[7:0];
            m_b    = g ? req_b[15:8] : req_b[7:0];
            m_src  = req_src[g];
            m_func = g ? req_func[3:2] : req_func[1:0];
            sb.push_back({g, m_a ^ m_b});
            if (m_cnt[g] < 255) m_cnt[g]++;
            m_st = 1;
         end else if (m_st == 1) begin
            if (sb.size() == 0) check("sb_empty", 1, 0);
            else m_rsp = sb[0];
            m_st = 2;
         end else if (m_st == 2 && rsp_ready) begin
            if (sb.size() != 0) void'(sb.pop_front());
            m_st = 0;
         end
      end
   end

   task automatic cyc(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_req(int i, logic src, logic [1:0] func, logic [7:0] in, logic [7:0] a, logic [7:0] b);
      req_src[i]         = src;
      req_func[i*2 +: 2] = func;
      req_in[i*8 +: 8]   = in;
      req_a[i*8 +: 8]    = a;
      req_b[i*8 +: 8]    = b;
   endtask

   task automatic wait_grant();
      int n = 0;
      #1;
      while (req_ready == 2'b00 && n < 20) begin
         cyc();
         #1;
         n++;
      end
      if (req_ready == 2'b00) check("grant_timeout", 0, 1);
      cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] a, b;
      cyc();
      mon_en = 1'b1;
      cyc();
      rst = 1'b0;
      check("reset_valid", rsp_valid, 0);
      check("reset_cnt", grant_cnt, 0);

      set_req(0, 1'b0, 2'd1, 8'd56, 8'd5, 8'd20);
      req_valid = 2'b01;
      #1;
      check("single_ready", req_ready, 2'b01);
      cyc();
      req_valid = 2'b00;
      check("single_func", dp_function, 1);
      check("single_early", rsp_valid, 0);
      cyc();
      check("single_valid", rsp_valid, 1);
      check("single_data", rsp_data, 17);
      check("single_id", rsp_id, 0);
      cyc();

      do_reset();
      set_req(0, 1'b1, 2'd2, 8'($urandom), 8'($urandom), 8'($urandom));
      set_req(1, 1'b0, 2'd3, 8'($urandom), 8'($urandom), 8'($urandom));
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("rr_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
         cyc();
         check("rr_exec_ready", req_ready, 0);
         cyc();
         check("rr_id", rsp_id, k % 2);
         cyc();
      end
      req_valid = 2'b00;
      cyc();

      a = 8'($urandom);
      b = 8'($urandom);
      set_req(0, 1'b0, 2'd0, 8'($urandom), a, b);
      rsp_ready = 1'b0;
      req_valid = 2'b01;
      wait_grant();
      cyc();
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", rsp_valid, 1);
         check("bp_data", rsp_data, a ^ b);
         check("bp_id", rsp_id, 0);
         check("bp_ready", req_ready, 0);
         cyc();
      end
      rsp_ready = 1'b1;
      req_valid = 2'b00;
      cyc();
      check("bp_done", rsp_valid, 0);

      set_req(0, 1'b1, 2'd3, 8'd7, 8'd9, 8'd11);
      req_valid = 2'b01;
      wait_grant();
      req_valid = 2'b00;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rst_valid", rsp_valid, 0);
      check("rst_inbus", dp_inbus, 0);
      check("rst_func", dp_function, 0);
      check("rst_data", rsp_data, 0);
      cyc(2);
      check("rst_no_rsp", rsp_valid, 0);
      set_req(1, 1'b0, 2'd1, 8'd1, 8'd2, 8'd3);
      req_valid = 2'b11;
      #1;
      check("rst_tie", req_ready, 2'b01);
      cyc();
      req_valid = 2'b00;
      cyc(3);

      for (int s = 0; s < 2; s++) begin
         for (int f = 0; f < 4; f++) begin
            set_req(1, 1'(s), 2'(f), 8'($urandom), 8'($urandom), 8'($urandom));
            req_valid = 2'b10;
            wait_grant();
            req_valid = 2'b00;
            check("sweep_src", dp_select_source, s);
            check("sweep_func", dp_function, f);
            cyc(2);
            check("hold_src", dp_select_source, s);
            check("hold_func", dp_function, f);
         end
      end

      do_reset();
      set_req(0, 1'b0, 2'd2, 8'd3, 8'd4, 8'd5);
      req_valid = 2'b01;
      cyc(900);
      req_valid = 2'b00;
      cyc(3);
`ifdef INTERCONNECT_ARB_STATS_EN
      check("stats_cnt0", grant_cnt[7:0], 255);
      check("stats_cnt1", grant_cnt[15:8], 0);
`else
      check("stats_off", grant_cnt, 0);
`endif
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
